// File: rtl/prbs_gen_chk_param.sv
// Parallel PRBS-7/9/15/23/31 generator and self-synchronising checker.
// The checker hunts for a clean run, then tracks the stream from its own prediction.
module prbs_gen_chk_param #(
    parameter int          W          = 64,
    parameter int          POLY       = 31,
    parameter logic [30:0] SEED       = '1,
    parameter int          LOCK_CNT   = 16,
    parameter int          UNLOCK_CNT = 4,
    parameter int          ERR_CNT_W  = 32
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 CE,
    input  logic                 INJ,
    output logic [W-1:0]         Q,
    input  logic                 DV,
    input  logic [W-1:0]         D,
    input  logic                 CLR,
    output logic                 LOCK,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int N  = POLY;
    localparam int T  = (POLY == 7)  ? 6  :
                        (POLY == 9)  ? 5  :
                        (POLY == 15) ? 14 :
                        (POLY == 23) ? 18 : 28;
    localparam int CW = $clog2(W + 1);
    localparam int SW = ((ERR_CNT_W > CW) ? ERR_CNT_W : CW) + 1;

    localparam logic [N-1:0] SEED_N =
        (SEED[N-1:0] == '0) ? '1 : SEED[N-1:0];
    localparam logic [W-1:0]         ONE  = 1;
    localparam logic [W-1:0]         TOP  = ONE << (W - 1);
    localparam logic [ERR_CNT_W-1:0] MAXV = '1;

    typedef enum logic {
        S_HUNT,
        S_LOCK
    } st_t;

    // state bit 0 is the newest bit; returns {next word, next state}
    function automatic logic [W+N-1:0] run(input logic [N-1:0] s_in);
        logic [N-1:0] s;
        logic [W-1:0] w;
        logic         nb;
        s = s_in;
        w = '0;
        for (int i = W - 1; i >= 0; i--) begin
            nb   = s[N-1] ^ s[T-1];
            w[i] = nb;
            s    = {s[N-2:0], nb};
        end
        return {w, s};
    endfunction

    // ---------------- generator ----------------
    logic [N-1:0]   gst;
    logic [W+N-1:0] gnx;

    assign gnx = run(gst);

    // advance W bits per enabled cycle; INJ flips only the output MSB
    always_ff @(posedge C) begin
        if (R) begin
            gst <= SEED_N;
            Q   <= '0;
        end else if (CE) begin
            gst <= gnx[N-1:0];
            Q   <= gnx[W+N-1:N] ^ (INJ ? TOP : '0);
        end
    end

    // ---------------- checker ----------------
    st_t                  st, st_n;
    logic [N-1:0]         cst, cst_n;
    logic [7:0]           clean_r, clean_n;
    logic [7:0]           bad_r, bad_n;
    logic                 err_r, err_n;
    logic [ERR_CNT_W-1:0] cnt_r, cnt_n;

    logic [W+N-1:0] pnx;
    logic [W-1:0]   pred;
    logic [W-1:0]   e;
    logic [CW-1:0]  n;
    logic [N-1:0]   hs;
    logic [SW-1:0]  sum;

    assign pnx  = run(cst);
    assign pred = pnx[W+N-1:N];
    assign e    = pred ^ D;
    assign sum  = SW'(cnt_r) + SW'(n);

    // bit-error popcount and the received-bit state used while hunting
    always_comb begin
        n  = '0;
        hs = cst;
        for (int i = W - 1; i >= 0; i--) begin
            n  = n + CW'(e[i]);
            hs = {hs[N-2:0], D[i]};
        end
    end

    // hunt/lock next-state, run counters and error accounting
    always_comb begin
        st_n    = st;
        cst_n   = cst;
        clean_n = clean_r;
        bad_n   = bad_r;
        err_n   = 1'b0;
        cnt_n   = cnt_r;
        if (DV) begin
            unique case (st)
                S_HUNT: begin
                    cst_n = hs;
                    if (n == '0 && cst != '0) begin
                        if (9'(clean_r) + 9'd1 >= 9'(LOCK_CNT)) begin
                            st_n    = S_LOCK;
                            clean_n = '0;
                            bad_n   = '0;
                        end else begin
                            clean_n = clean_r + 8'd1;
                        end
                    end else begin
                        clean_n = '0;
                    end
                end
                S_LOCK: begin
                    cst_n = pnx[N-1:0];
                    err_n = (n != '0);
                    cnt_n = (sum > SW'(MAXV)) ? MAXV
                                              : sum[ERR_CNT_W-1:0];
                    if (n != '0) begin
                        if (9'(bad_r) + 9'd1 >= 9'(UNLOCK_CNT)) begin
                            st_n    = S_HUNT;
                            clean_n = '0;
                            bad_n   = '0;
                        end else begin
                            bad_n = bad_r + 8'd1;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: st_n = S_HUNT;
            endcase
        end
        if (CLR) begin
            cnt_n = '0;
        end
    end

    // checker state register
    always_ff @(posedge C) begin
        if (R) begin
            st      <= S_HUNT;
            cst     <= '0;
            clean_r <= '0;
            bad_r   <= '0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            st      <= st_n;
            cst     <= cst_n;
            clean_r <= clean_n;
            bad_r   <= bad_n;
            err_r   <= err_n;
            cnt_r   <= cnt_n;
        end
    end

    assign LOCK    = (st == S_LOCK);
    assign ERR     = err_r;
    assign ERR_CNT = cnt_r;

endmodule

// File: tb/tb_prbs_gen_chk_param.sv
// Bench for prbs_gen_chk_param: a W=64/PRBS-31 instance and a
// W=8/PRBS-7 instance with an 8-bit error counter.
module tb_prbs_gen_chk_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // ---- instance A: W=64, PRBS-31 ----
    logic        a_r, a_ce, a_inj, a_dv, a_clr, a_loop;
    logic [63:0] a_q, a_dman, a_flip, a_d;
    logic        a_lock, a_err;
    logic [31:0] a_cnt;

    assign a_d = a_loop ? (a_q ^ a_flip) : a_dman;

    prbs_gen_chk_param #(
        .W(64), .POLY(31), .LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(32)
    ) u_a (
        .C(clk), .R(a_r), .CE(a_ce), .INJ(a_inj), .Q(a_q),
        .DV(a_dv), .D(a_d), .CLR(a_clr),
        .LOCK(a_lock), .ERR(a_err), .ERR_CNT(a_cnt)
    );

    // ---- instance B: W=8, PRBS-7, 8-bit counter ----
    logic       b_r, b_ce, b_inj, b_dv, b_clr, b_loop;
    logic [7:0] b_q, b_dman, b_d;
    logic       b_lock, b_err;
    logic [7:0] b_cnt;

    assign b_d = b_loop ? b_q : b_dman;

    prbs_gen_chk_param #(
        .W(8), .POLY(7), .LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(8)
    ) u_b (
        .C(clk), .R(b_r), .CE(b_ce), .INJ(b_inj), .Q(b_q),
        .DV(b_dv), .D(b_d), .CLR(b_clr),
        .LOCK(b_lock), .ERR(b_err), .ERR_CNT(b_cnt)
    );

    typedef struct {
        logic       ce;
        logic       inj;
        logic [7:0] q;
    } vec_t;

    vec_t vt[7];
    logic ref_bits[0:366];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int   at;
        int   nerr;
        logic lk_ok;
        logic [7:0] w;

        // hand-computed PRBS-7 words from the all-ones seed
        vt[0] = '{1'b1, 1'b0, 8'h02};
        vt[1] = '{1'b1, 1'b0, 8'h0C};
        vt[2] = '{1'b0, 1'b0, 8'h0C};
        vt[3] = '{1'b1, 1'b0, 8'h28};
        vt[4] = '{1'b1, 1'b1, 8'h72};
        vt[5] = '{1'b0, 1'b1, 8'h72};
        vt[6] = '{1'b1, 1'b0, 8'h2C};

        for (int i = 0; i < 7; i++) ref_bits[i] = 1'b1;
        for (int i = 7; i < 367; i++)
            ref_bits[i] = ref_bits[i-7] ^ ref_bits[i-6];

        a_r = 1; a_ce = 0; a_inj = 0; a_dv = 0; a_clr = 0;
        a_loop = 0; a_dman = '0; a_flip = '0;
        b_r = 1; b_ce = 0; b_inj = 0; b_dv = 0; b_clr = 0;
        b_loop = 0; b_dman = '0;
        tick(); tick();
        a_r = 0; b_r = 0;

        chk("a_reset_q", 128'(a_q), 128'h0);
        chk("a_reset_lock", 128'(a_lock), 128'h0);
        chk("a_reset_err", 128'(a_err), 128'h0);
        chk("a_reset_cnt", 128'(a_cnt), 128'h0);
        chk("b_reset_q", 128'(b_q), 128'h0);
        chk("b_reset_lock", 128'(b_lock), 128'h0);

        // generator table on B (CE gaps, INJ output-only)
        for (int i = 0; i < 7; i++) begin
            b_ce = vt[i].ce; b_inj = vt[i].inj;
            tick();
            chk($sformatf("b_vec%0d", i), 128'(b_q), 128'(vt[i].q));
        end
        b_inj = 0;

        // next 40 words against the bit-serial reference
        b_ce = 1;
        for (int k = 5; k < 45; k++) begin
            tick();
            for (int j = 0; j < 8; j++) w[7-j] = ref_bits[7 + 8*k + j];
            chk($sformatf("b_serial%0d", k), 128'(b_q), 128'(w));
        end

        // A: loopback lock-up
        a_r = 1; tick(); a_r = 0;
        a_loop = 1; a_ce = 1;
        tick();
        a_dv = 1;
        at = 0; nerr = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (a_lock && at == 0) at = i;
            if (a_err) nerr++;
        end
        chk("a_lock_word", 128'(at), 128'd17);
        chk("a_lock_100", 128'(a_lock), 128'h1);
        chk("a_cnt_clean", 128'(a_cnt), 128'h0);
        chk("a_err_clean", 128'(nerr), 128'd0);

        // A: single injected bit
        a_inj = 1; tick(); a_inj = 0;
        nerr = 0; lk_ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_err) nerr++;
            if (!a_lock) lk_ok = 0;
        end
        chk("a_inj_errpulse", 128'(nerr), 128'd1);
        chk("a_inj_cnt", 128'(a_cnt), 128'd1);
        chk("a_inj_lock", 128'(lk_ok), 128'h1);

        // A: CLR, then four inverted words
        a_clr = 1; tick(); a_clr = 0;
        chk("a_clr_cnt", 128'(a_cnt), 128'h0);
        a_flip = '1;
        tick(); tick(); tick();
        chk("a_inv3_lock", 128'(a_lock), 128'h1);
        tick();
        a_flip = '0;
        chk("a_inv4_lock", 128'(a_lock), 128'h0);
        chk("a_inv4_cnt", 128'(a_cnt), 128'd256);
        at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (a_lock && at == 0) at = i;
        end
        chk("a_relock_word", 128'(at), 128'd16);
        chk("a_relock_cnt", 128'(a_cnt), 128'd256);

        // A: constant zero input never locks
        a_r = 1; tick(); a_r = 0;
        a_loop = 0; a_dman = '0; a_dv = 1;
        lk_ok = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (a_lock) lk_ok = 0;
        end
        chk("a_zero_nolock", 128'(lk_ok), 128'h1);
        chk("a_zero_cnt", 128'(a_cnt), 128'h0);
        a_dv = 0;

        // B: lock, then saturate the counter
        b_r = 1; tick(); b_r = 0;
        b_loop = 1; b_ce = 1;
        tick();
        b_dv = 1;
        at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (b_lock && at == 0) at = i;
        end
        chk("b_lock_word", 128'(at), 128'd17);
        lk_ok = 1;
        for (int i = 0; i < 300; i++) begin
            b_inj = 1; tick();
            b_inj = 0; tick();
            if (!b_lock) lk_ok = 0;
        end
        chk("b_sat_cnt", 128'(b_cnt), 128'd255);
        chk("b_sat_lock", 128'(lk_ok), 128'h1);

        // B: CLR coinciding with an injected error
        b_inj = 1; b_clr = 1; tick();
        b_inj = 0; tick();
        b_clr = 0; tick(); tick();
        chk("b_clrinj_cnt", 128'(b_cnt), 128'h0);
        chk("b_clrinj_lock", 128'(b_lock), 128'h1);

        // B: reset mid-lock
        b_r = 1; tick(); b_r = 0;
        chk("b_rst_lock", 128'(b_lock), 128'h0);
        chk("b_rst_q", 128'(b_q), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
